// File: rtl/mult_seq_pkg.sv
// Shared types for the multiplier issue sequencer: command encoding, FSM states and the in-flight tag.
package mult_seq_pkg;

  localparam int MULT_CMD_W = 2;
  localparam int MULT_RD_W  = 5;

  typedef enum logic [MULT_CMD_W-1:0] {
    CMD_MULHSU = 2'b00,
    CMD_MUL    = 2'b01,
    CMD_MULH   = 2'b10,
    CMD_MULHU  = 2'b11
  } mult_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [MULT_RD_W-1:0] rd;
    mult_cmd_t            cmd;
    logic                 epoch;
  } mult_tag_t;

endpackage

// File: rtl/mult_seq_tag_fifo.sv
// Show-ahead circular FIFO of in-flight multiply tags; head_dat is valid whenever empty is low.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
module mult_seq_tag_fifo
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  mult_tag_t                push_dat,
  input  logic                     pop,
  output mult_tag_t                head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mult_tag_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mult_issue_sequencer.sv
// Issue/retire controller for the 3-stage multiplier; optional perf counters under MULT_SEQ_PERF_EN.
// Latency: 0-cycle issue (x0_push_o with accept), 0-cycle retire from X2 head to writeback.
// Backpressure: req_ready_o drops on flush, DRAIN, X0 full or tag queue full; wb_ready_i holds the X2 head.
module mult_issue_sequencer
  import mult_seq_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int RD_W         = MULT_RD_W  // must match the tag's rd field width
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [MULT_CMD_W-1:0]           req_cmd_i,
  input  logic [RD_W-1:0]                 req_rd_i,
  input  logic                            x0_full_i,
  output logic                            x0_push_o,
  output logic [MULT_CMD_W-1:0]           x0_cmd_o,
  input  logic                            res_valid_i,
  output logic                            res_pop_o,
  output logic                            wb_valid_o,
  output logic [RD_W-1:0]                 wb_rd_o,
  output logic [MULT_CMD_W-1:0]           wb_cmd_o,
  input  logic                            wb_ready_i,
  input  logic                            flush_i,
  output logic                            busy_o,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
  output logic                            err_o,
  output logic [31:0]                     perf_issued_o,
  output logic [31:0]                     perf_retired_o,
  output logic [31:0]                     perf_dropped_o,
  output logic [31:0]                     perf_stall_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             epoch;
  logic             err_q;
  mult_tag_t        push_tag;
  mult_tag_t        head;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_nxt;
  logic             req_rdy;
  logic             accept;
  logic             head_live;
  logic             head_squash;
  logic             orphan;
  logic             wb_fire;
  logic             q_pop;

  assign req_rdy     = ~reset & ~flush_i & (state != ST_DRAIN) & ~x0_full_i & ~q_full;
  assign accept      = req_valid_i & req_rdy;
  // Epoch compare uses the current epoch, so a flush-cycle pop still sees pre-flush ownership.
  assign head_live   = ~reset & res_valid_i & ~q_empty & (head.epoch == epoch);
  assign head_squash = ~reset & res_valid_i & ~q_empty & (head.epoch != epoch);
  assign orphan      = ~reset & res_valid_i & q_empty;
  assign wb_fire     = head_live & wb_ready_i;
  assign q_pop       = wb_fire | head_squash;

  assign inflight_nxt = inflight + CNT_W'(accept) - CNT_W'(q_pop);
  assign push_tag     = '{rd: MULT_RD_W'(req_rd_i), cmd: mult_cmd_t'(req_cmd_i), epoch: epoch};

  mult_seq_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_dat (push_tag),
    .pop      (q_pop),
    .head_dat (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (inflight)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      epoch <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush_i) epoch <= ~epoch;
      if (orphan)  err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = (inflight_nxt != '0) ? ST_DRAIN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (inflight_nxt != '0) state_nxt = ST_BUSY;
        ST_BUSY:  if (inflight_nxt == '0) state_nxt = ST_IDLE;
        ST_DRAIN: if (inflight_nxt == '0) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    x0_push_o   = 1'b0;
    x0_cmd_o    = '0;
    res_pop_o   = 1'b0;
    wb_valid_o  = 1'b0;
    wb_rd_o     = '0;
    wb_cmd_o    = '0;
    busy_o      = 1'b0;
    if (!reset) begin
      req_ready_o = req_rdy;
      x0_push_o   = accept;
      x0_cmd_o    = req_cmd_i;
      res_pop_o   = q_pop | orphan;
      wb_valid_o  = head_live;
      wb_rd_o     = RD_W'(head.rd);
      wb_cmd_o    = head.cmd;
      busy_o      = (state != ST_IDLE);
    end
  end

  assign inflight_o = inflight;
  assign err_o      = err_q;

`ifdef MULT_SEQ_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_retired;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued  <= '0;
      perf_retired <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (accept)                 perf_issued  <= perf_issued + 32'd1;
      if (wb_fire)                perf_retired <= perf_retired + 32'd1;
      if (head_squash)            perf_dropped <= perf_dropped + 32'd1;
      if (req_valid_i & ~req_rdy) perf_stall   <= perf_stall + 32'd1;
    end
  end

  assign perf_issued_o  = perf_issued;
  assign perf_retired_o = perf_retired;
  assign perf_dropped_o = perf_dropped;
  assign perf_stall_o   = perf_stall;
`else
  assign perf_issued_o  = '0;
  assign perf_retired_o = '0;
  assign perf_dropped_o = '0;
  assign perf_stall_o   = '0;
`endif

endmodule

// File: tb/tb_mult_issue_sequencer.sv
// Scoreboard bench for mult_issue_sequencer: directed scenarios plus random traffic against a queue model.
module tb_mult_issue_sequencer;

  localparam int MAXI = 4;
  localparam int RDW  = 5;
  localparam int CW   = $clog2(MAXI) + 1;
`ifdef MULT_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid_i, req_ready_o;
  logic [1:0]      req_cmd_i;
  logic [RDW-1:0]  req_rd_i;
  logic            x0_full_i, x0_push_o;
  logic [1:0]      x0_cmd_o;
  logic            res_valid_i, res_pop_o;
  logic            wb_valid_o, wb_ready_i;
  logic [RDW-1:0]  wb_rd_o;
  logic [1:0]      wb_cmd_o;
  logic            flush_i, busy_o, err_o;
  logic [CW-1:0]   inflight_o;
  logic [31:0]     perf_issued_o, perf_retired_o, perf_dropped_o, perf_stall_o;

  always #5 clk = ~clk;

  mult_issue_sequencer #(.MAX_INFLIGHT(MAXI), .RD_W(RDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i), .req_rd_i(req_rd_i),
    .x0_full_i(x0_full_i), .x0_push_o(x0_push_o), .x0_cmd_o(x0_cmd_o),
    .res_valid_i(res_valid_i), .res_pop_o(res_pop_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_cmd_o(wb_cmd_o),
    .wb_ready_i(wb_ready_i), .flush_i(flush_i), .busy_o(busy_o),
    .inflight_o(inflight_o), .err_o(err_o),
    .perf_issued_o(perf_issued_o), .perf_retired_o(perf_retired_o),
    .perf_dropped_o(perf_dropped_o), .perf_stall_o(perf_stall_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of outstanding ops, one epoch bit, a drain flag.
  typedef struct {
    logic [RDW-1:0] rd;
    logic [1:0]     cmd;
    logic           ep;
  } mtag_t;

  mtag_t       mq[$];
  logic [6:0]  exp_wb[$];
  bit          m_epoch, m_err, m_drain;
  int unsigned m_iss, m_ret, m_drp, m_stl;

  // One cycle: called at posedge+1 with inputs driven, returns at the next posedge+1.
  task automatic step();
    bit m_rdy, m_acc, m_pop, m_wbv, m_drop, m_orph, m_ret_now;
    m_rdy = 0; m_acc = 0; m_pop = 0; m_wbv = 0; m_drop = 0; m_orph = 0; m_ret_now = 0;
    chk("wb_missing", 32'(exp_wb.size()), 32'd0);
    if (!reset) begin
      m_rdy = !flush_i && !m_drain && !x0_full_i && (mq.size() < MAXI);
      m_acc = req_valid_i && m_rdy;
      if (res_valid_i) begin
        if (mq.size() == 0) begin
          m_pop = 1; m_orph = 1;
        end else if (mq[0].ep == m_epoch) begin
          m_wbv = 1; m_pop = wb_ready_i; m_ret_now = wb_ready_i;
        end else begin
          m_pop = 1; m_drop = 1;
        end
      end
      if (m_ret_now) exp_wb.push_back({mq[0].rd, mq[0].cmd});
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready_o), 32'(m_rdy));
    chk("x0_push", 32'(x0_push_o), 32'(m_acc));
    chk("res_pop", 32'(res_pop_o), 32'(m_pop));
    chk("wb_valid", 32'(wb_valid_o), 32'(m_wbv));
    if (reset) begin
      chk("busy_rst", 32'(busy_o), 32'd0);
      chk("x0_cmd_rst", 32'(x0_cmd_o), 32'd0);
      chk("wb_rd_rst", 32'(wb_rd_o), 32'd0);
    end else begin
      chk("busy", 32'(busy_o), 32'(mq.size() != 0));
      chk("inflight", 32'(inflight_o), 32'(mq.size()));
      chk("err", 32'(err_o), 32'(m_err));
      if (m_acc) chk("x0_cmd", 32'(x0_cmd_o), 32'(req_cmd_i));
      if (m_wbv) chk("wb_rd_head", 32'(wb_rd_o), 32'(mq[0].rd));
      chk("perf_issued", perf_issued_o, PERF ? m_iss : 32'd0);
      chk("perf_retired", perf_retired_o, PERF ? m_ret : 32'd0);
      chk("perf_dropped", perf_dropped_o, PERF ? m_drp : 32'd0);
      chk("perf_stall", perf_stall_o, PERF ? m_stl : 32'd0);
    end
    if (reset) begin
      mq.delete(); exp_wb.delete();
      m_epoch = 0; m_err = 0; m_drain = 0;
      m_iss = 0; m_ret = 0; m_drp = 0; m_stl = 0;
    end else begin
      if (m_pop && mq.size() > 0) void'(mq.pop_front());
      if (m_acc) mq.push_back('{rd: req_rd_i, cmd: req_cmd_i, ep: m_epoch});
      if (m_orph) m_err = 1;
      if (m_acc) m_iss++;
      if (m_ret_now) m_ret++;
      if (m_drop) m_drp++;
      if (req_valid_i && !m_rdy) m_stl++;
      if (flush_i) begin
        m_epoch = !m_epoch;
        m_drain = (mq.size() > 0);
      end else if (mq.size() == 0) begin
        m_drain = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit rv, input bit [1:0] cmd, input bit [RDW-1:0] rd,
                     input bit xf, input bit rsv, input bit wbr, input bit fl);
    req_valid_i = rv; req_cmd_i = cmd; req_rd_i = rd;
    x0_full_i = xf; res_valid_i = rsv; wb_ready_i = wbr; flush_i = fl;
    step();
  endtask

  // Monitor: every writeback handshake must match the oldest expected entry.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!reset && wb_valid_o && wb_ready_i) begin
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got rd %0d with nothing expected at %0t", wb_rd_o, $time);
        end else begin
          e = exp_wb.pop_front();
          chk("wb_rd", 32'(wb_rd_o), 32'(e[6:2]));
          chk("wb_cmd", 32'(wb_cmd_o), 32'(e[1:0]));
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1; req_valid_i = 0; req_cmd_i = 0; req_rd_i = 0;
    x0_full_i = 0; res_valid_i = 0; wb_ready_i = 0; flush_i = 0;
    @(posedge clk); #1;
    drv(1, 2'b01, 5'd9, 0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0);

    // Three back-to-back MULs then in-order retire
    for (int i = 1; i <= 3; i++) drv(1, 2'b01, 5'(i), 0, 0, 0, 0);
    repeat (3) drv(0, 0, 0, 0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0);

    // Fill the queue; a same-cycle pop does not open ready
    for (int i = 0; i < 4; i++) drv(1, 2'($urandom), 5'(10 + i), 0, 0, 0, 0);
    drv(1, 2'b01, 5'd20, 0, 1, 1, 0);
    drv(1, 2'b10, 5'd21, 0, 0, 0, 0);
    drv(1, 2'b11, 5'd22, 0, 0, 0, 0);
    repeat (4) drv(0, 0, 0, 0, 1, 1, 0);

    // Flush with two in flight: both squashed, then a fresh accept retires live
    drv(1, 2'b10, 5'd5, 0, 0, 0, 0);
    drv(1, 2'b10, 5'd6, 0, 0, 0, 0);
    drv(1, 2'b10, 5'd7, 0, 0, 0, 1);
    drv(1, 2'b10, 5'd8, 0, 1, 1, 0);
    drv(0, 0, 0, 0, 1, 1, 0);
    drv(1, 2'b11, 5'd9, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 0);

    // Writeback stall holds the head for three cycles
    drv(1, 2'b00, 5'd17, 0, 0, 0, 0);
    repeat (3) drv(0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 0);

    // Random traffic; results only offered while something is outstanding
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 2) != 0, 2'($urandom), 5'($urandom), $urandom_range(0, 4) == 0,
          (mq.size() > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0);
    end
    guard = 0;
    while (mq.size() > 0 && guard < 100) begin
      drv(0, 0, 0, 0, 1, 1, 0);
      guard++;
    end
    chk("drain_done", 32'(mq.size()), 32'd0);

    // Result with nothing outstanding: sticky error
    drv(0, 0, 0, 0, 1, 1, 0);
    repeat (3) drv(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation with three in flight
    for (int i = 0; i < 3; i++) drv(1, 2'b01, 5'(24 + i), 0, 0, 0, 0);
    reset = 1;
    drv(1, 2'b01, 5'd30, 0, 1, 1, 0);
    reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 2'b01, 5'd31, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
